// File: rtl/approx_mult_pipe.sv
`default_nettype none
// approx_mult_pipe: pipelined unsigned WIDTH x WIDTH multiplier where the lowest K columns
// are OR-compressed instead of summed. Revision 1.0.

module approx_mult_pipe #(
   parameter int WIDTH       = 6,
   parameter int APPROX_COLS = 4,
   parameter int STAGES      = 3,
   parameter int KSEL_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic [KSEL_W-1:0]    k_sel,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic [KSEL_W-1:0]    out_k,
   output logic [15:0]          ops_cnt
);

   localparam int                PW     = 2*WIDTH;
   localparam logic [KSEL_W-1:0] C_MAXK = KSEL_W'(APPROX_COLS);

   logic [KSEL_W-1:0] k_d;
   logic [PW-1:0]     prod_d;
   logic [PW-1:0]     lo_or;
   logic              en;

   logic [PW-1:0]     prod_q [STAGES];
   logic [KSEL_W-1:0] k_q    [STAGES];
   logic              vld_q  [STAGES];
   logic [15:0]       ops_cnt_q;

   assign k_d = (k_sel > C_MAXK) ? C_MAXK : k_sel;

   // High columns are a multiple of 2^K, so merging the OR bits is a plain OR.
   always_comb begin
      prod_d = '0;
      lo_or  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            if ((i + j) >= int'(k_d)) begin
               prod_d = prod_d + (PW'(a[i] & b[j]) << (i + j));
            end else begin
               lo_or[i+j] = lo_or[i+j] | (a[i] & b[j]);
            end
         end
      end
      prod_d = prod_d | lo_or;
   end

   assign en       = !vld_q[STAGES-1] || out_ready;
   assign in_ready = en;

   // Whole pipe advances or holds as one; bubbles are deliberately not squeezed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < STAGES; s++) begin
            prod_q[s] <= '0;
            k_q[s]    <= '0;
            vld_q[s]  <= 1'b0;
         end
      end else if (en) begin
         prod_q[0] <= prod_d;
         k_q[0]    <= k_d;
         vld_q[0]  <= in_valid;
         for (int s = 1; s < STAGES; s++) begin
            prod_q[s] <= prod_q[s-1];
            k_q[s]    <= k_q[s-1];
            vld_q[s]  <= vld_q[s-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ops_cnt_q <= '0;
      end else if (vld_q[STAGES-1] && out_ready) begin
         ops_cnt_q <= ops_cnt_q + 16'd1;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign prod      = prod_q[STAGES-1];
   assign out_k     = k_q[STAGES-1];
   assign ops_cnt   = ops_cnt_q;

endmodule

`default_nettype wire
